// File: rtl/decode_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_operand_stage_if
// Description : Bundle of the decode/operand-fetch stage's external signals:
//               instruction valid/ready input side, decoded-operand
//               valid/ready output side, and register-file writeback port.
//               master = upstream/downstream environment, slave = the stage.
// Ports       : in_valid/in_ready/in_instr, out_valid/out_ready/out_a/out_b/
//               out_sel/out_rd/out_illegal, wb_en/wb_addr/wb_data
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_operand_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [2:0]  out_sel;
   logic [4:0]  out_rd;
   logic        out_illegal;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   modport master (
      output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
      input  in_ready, out_valid, out_a, out_b, out_sel, out_rd, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
      output in_ready, out_valid, out_a, out_b, out_sel, out_rd, out_illegal
   );
endinterface
`default_nettype wire

// File: rtl/decode_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_operand_stage
// Description : Decode and operand-fetch stage ahead of the 32-bit ALU.
//               Accepts MIPS R-type words, reads operands from a 32x32
//               register file (with writeback bypass), maps funct to the
//               ALU select code and presents the result from one output
//               pipeline register under valid/ready flow control.
// Ports       : clk - rising-edge clock
//               rst - synchronous active-high reset
//               bus - decode_operand_stage_if.slave (handshake, outputs, wb)
// Revision    : 1.0 - initial release
// ============================================================================
module decode_operand_stage #(
   parameter logic [31:0] REG_RESET_VALUE = 32'h0000_0000
) (
   input  wire logic             clk,
   input  wire logic             rst,
   decode_operand_stage_if.slave bus
);
   localparam logic [2:0] C_SEL_ADD = 3'b000;
   localparam logic [2:0] C_SEL_MUL = 3'b001;
   localparam logic [2:0] C_SEL_AND = 3'b010;
   localparam logic [2:0] C_SEL_OR  = 3'b011;
   localparam logic [2:0] C_SEL_XOR = 3'b100;
   localparam logic [2:0] C_SEL_NOR = 3'b101;
   localparam logic [2:0] C_SEL_SLL = 3'b110;
   localparam logic [2:0] C_SEL_SRL = 3'b111;

   logic [31:0] rf_q [32];

   // Output bundle plus the source addresses/kind needed for held refresh
   logic        valid_q;
   logic [31:0] a_q, b_q;
   logic [2:0]  sel_q;
   logic [4:0]  rd_q, rs_q, rt_q;
   logic        illegal_q, shift_q;

   logic [31:0] a_d, b_d;
   logic [2:0]  sel_d;
   logic        illegal_d, shift_d;
   logic [31:0] rs_val, rt_val;

   logic        accept, xfer, wb_live;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;

   assign opcode = bus.in_instr[31:26];
   assign rs     = bus.in_instr[25:21];
   assign rt     = bus.in_instr[20:16];
   assign rd     = bus.in_instr[15:11];
   assign shamt  = bus.in_instr[10:6];
   assign funct  = bus.in_instr[5:0];

   assign bus.in_ready = !valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign xfer         = valid_q && bus.out_ready;
   // Writes to R0 are dropped, so they never bypass or refresh either
   assign wb_live      = bus.wb_en && (bus.wb_addr != 5'd0);

   always_comb begin
      rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
      if (wb_live && (bus.wb_addr == rs)) rs_val = bus.wb_data;
      rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];
      if (wb_live && (bus.wb_addr == rt)) rt_val = bus.wb_data;

      sel_d     = C_SEL_ADD;
      illegal_d = 1'b0;
      shift_d   = 1'b0;
      if (opcode != 6'd0) begin
         illegal_d = 1'b1;
      end else begin
         case (funct)
            6'd32:   sel_d = C_SEL_ADD;
            6'd24:   sel_d = C_SEL_MUL;
            6'd36:   sel_d = C_SEL_AND;
            6'd37:   sel_d = C_SEL_OR;
            6'd38:   sel_d = C_SEL_XOR;
            6'd39:   sel_d = C_SEL_NOR;
            6'd0:    begin sel_d = C_SEL_SLL; shift_d = 1'b1; end
            6'd2:    begin sel_d = C_SEL_SRL; shift_d = 1'b1; end
            default: illegal_d = 1'b1;
         endcase
      end

      if (illegal_d) begin
         a_d = 32'd0;
         b_d = 32'd0;
      end else if (shift_d) begin
         a_d = rt_val;
         b_d = {27'd0, shamt};
      end else begin
         a_d = rs_val;
         b_d = rt_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= (i == 0) ? 32'd0 : REG_RESET_VALUE;
         end
         valid_q   <= 1'b0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         sel_q     <= 3'd0;
         rd_q      <= 5'd0;
         rs_q      <= 5'd0;
         rt_q      <= 5'd0;
         illegal_q <= 1'b0;
         shift_q   <= 1'b0;
      end else begin
         if (wb_live) rf_q[bus.wb_addr] <= bus.wb_data;

         if (accept) begin
            valid_q   <= 1'b1;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            rd_q      <= rd;
            rs_q      <= rs;
            rt_q      <= rt;
            illegal_q <= illegal_d;
            shift_q   <= shift_d;
         end else if (xfer) begin
            valid_q <= 1'b0;
         end else if (valid_q && !illegal_q && wb_live) begin
            // Held bundle: keep operands coherent with the register file.
            // A shift's B is the shamt immediate and is never refreshed.
            if (shift_q) begin
               if (bus.wb_addr == rt_q) a_q <= bus.wb_data;
            end else begin
               if (bus.wb_addr == rs_q) a_q <= bus.wb_data;
               if (bus.wb_addr == rt_q) b_q <= bus.wb_data;
            end
         end
      end
   end

   assign bus.out_valid   = valid_q;
   assign bus.out_a       = a_q;
   assign bus.out_b       = b_q;
   assign bus.out_sel     = sel_q;
   assign bus.out_rd      = rd_q;
   assign bus.out_illegal = illegal_q;
endmodule
`default_nettype wire

// File: tb/tb_decode_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_operand_stage
// Description : Self-checking bench for decode_operand_stage. A reference
//               register file and a queue of expected bundles track the
//               stage; directed tasks add constant-value checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_operand_stage;
   localparam logic [31:0] RV = 32'h1357_9BDF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_operand_stage_if bus();

   decode_operand_stage #(.REG_RESET_VALUE(RV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  sel;
      logic [4:0]  rd;
      logic        ill;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        shift;
   } exp_t;

   int          total = 0;
   int          bad   = 0;
   exp_t        sb[$];
   logic [31:0] m_rf [32];
   logic        m_valid;

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s,
                                      input logic [4:0] t, input logic [4:0] d,
                                      input logic [4:0] sh, input logic [5:0] fn);
      return {op, s, t, d, sh, fn};
   endfunction

   function automatic logic [31:0] rdv(input logic [4:0] addr);
      if (addr == 5'd0) return 32'd0;
      if (bus.wb_en && bus.wb_addr == addr) return bus.wb_data;
      return m_rf[addr];
   endfunction

   function automatic exp_t model_decode(input logic [31:0] ins);
      exp_t e;
      e       = '0;
      e.rs    = ins[25:21];
      e.rt    = ins[20:16];
      e.rd    = ins[15:11];
      e.ill   = 1'b0;
      if (ins[31:26] != 6'd0) e.ill = 1'b1;
      else case (ins[5:0])
         6'd32: e.sel = 3'd0;
         6'd24: e.sel = 3'd1;
         6'd36: e.sel = 3'd2;
         6'd37: e.sel = 3'd3;
         6'd38: e.sel = 3'd4;
         6'd39: e.sel = 3'd5;
         6'd0:  begin e.sel = 3'd6; e.shift = 1'b1; end
         6'd2:  begin e.sel = 3'd7; e.shift = 1'b1; end
         default: e.ill = 1'b1;
      endcase
      if (e.ill) begin
         e.sel = 3'd0; e.a = 32'd0; e.b = 32'd0; e.shift = 1'b0;
      end else if (e.shift) begin
         e.a = rdv(e.rt); e.b = {27'd0, ins[10:6]};
      end else begin
         e.a = rdv(e.rs); e.b = rdv(e.rt);
      end
      return e;
   endfunction

   // One clock: check at negedge against the model, advance the model,
   // then return 1 time unit after the rising edge.
   task automatic step();
      exp_t e;
      logic exp_rdy, acc, xfer;
      @(negedge clk);
      if (rst) begin
         @(posedge clk);
         sb.delete();
         m_valid = 1'b0;
         for (int i = 0; i < 32; i++) m_rf[i] = (i == 0) ? 32'd0 : RV;
         #1;
         return;
      end
      exp_rdy = !m_valid || bus.out_ready;
      total++;
      if (bus.in_ready !== exp_rdy) begin
         bad++; $display("FAIL in_ready: got %b want %b at %0t", bus.in_ready, exp_rdy, $time);
      end
      total++;
      if (bus.out_valid !== m_valid) begin
         bad++; $display("FAIL out_valid: got %b want %b at %0t", bus.out_valid, m_valid, $time);
      end
      if (m_valid) begin
         total++;
         if (sb.size() == 0) begin
            bad++; $display("FAIL scoreboard_empty: got out_valid with no expected bundle at %0t", $time);
         end else begin
            e = sb[0];
            if ({bus.out_a, bus.out_b, bus.out_sel, bus.out_rd, bus.out_illegal} !==
                {e.a, e.b, e.sel, e.rd, e.ill}) begin
               bad++;
               $display("FAIL bundle: got a=%h b=%h sel=%b rd=%0d ill=%b want a=%h b=%h sel=%b rd=%0d ill=%b at %0t",
                        bus.out_a, bus.out_b, bus.out_sel, bus.out_rd, bus.out_illegal,
                        e.a, e.b, e.sel, e.rd, e.ill, $time);
            end
         end
      end
      acc  = bus.in_valid && exp_rdy;
      xfer = m_valid && bus.out_ready;
      if (xfer && sb.size() > 0) begin
         void'(sb.pop_front());
      end else if (m_valid && !xfer && sb.size() > 0 && bus.wb_en && bus.wb_addr != 5'd0) begin
         e = sb[0];
         if (!e.ill) begin
            if (e.shift) begin
               if (bus.wb_addr == e.rt) e.a = bus.wb_data;
            end else begin
               if (bus.wb_addr == e.rs) e.a = bus.wb_data;
               if (bus.wb_addr == e.rt) e.b = bus.wb_data;
            end
            sb[0] = e;
         end
      end
      if (acc) sb.push_back(model_decode(bus.in_instr));
      if (acc) m_valid = 1'b1;
      else if (xfer) m_valid = 1'b0;
      if (bus.wb_en && bus.wb_addr != 5'd0) m_rf[bus.wb_addr] = bus.wb_data;
      @(posedge clk);
      #1;
   endtask

   task automatic do_wb(input logic [4:0] addr, input logic [31:0] data);
      bus.wb_en = 1'b1; bus.wb_addr = addr; bus.wb_data = data;
      step();
      bus.wb_en = 1'b0;
   endtask

   task automatic send(input logic [31:0] ins);
      bus.in_valid = 1'b1; bus.in_instr = ins;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b0;
      bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
      step();
      rst = 1'b0;
      total++;
      if ({bus.out_valid, bus.out_a, bus.out_b, bus.out_sel, bus.out_rd, bus.out_illegal} !== '0) begin
         bad++; $display("FAIL reset_outputs: got v=%b a=%h b=%h sel=%b rd=%0d ill=%b want all zero",
                         bus.out_valid, bus.out_a, bus.out_b, bus.out_sel, bus.out_rd, bus.out_illegal);
      end
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_alu();
      do_wb(5'd3, 32'd5);
      do_wb(5'd4, 32'd7);
      bus.out_ready = 1'b1;
      send(32'h0064_1020);
      total++;
      if ({bus.out_valid, bus.out_a, bus.out_b, bus.out_sel, bus.out_rd} !== {1'b1, 32'd5, 32'd7, 3'b000, 5'd2}) begin
         bad++; $display("FAIL alu_add: got v=%b a=%h b=%h sel=%b rd=%0d want 1 5 7 000 2",
                         bus.out_valid, bus.out_a, bus.out_b, bus.out_sel, bus.out_rd);
      end
   endtask

   task automatic test_shift();
      send(32'h0004_28C0);
      total++;
      if ({bus.out_a, bus.out_b, bus.out_sel, bus.out_rd} !== {32'd7, 32'd3, 3'b110, 5'd5}) begin
         bad++; $display("FAIL shift_sll: got a=%h b=%h sel=%b rd=%0d want 7 3 110 5",
                         bus.out_a, bus.out_b, bus.out_sel, bus.out_rd);
      end
      send(mk(6'd0, 5'd9, 5'd4, 5'd6, 5'd31, 6'd2));
      total++;
      if ({bus.out_a, bus.out_b, bus.out_sel} !== {32'd7, 32'd31, 3'b111}) begin
         bad++; $display("FAIL shift_srl31: got a=%h b=%h sel=%b want 7 31 111",
                         bus.out_a, bus.out_b, bus.out_sel);
      end
   endtask

   task automatic test_bypass();
      bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'hFFFF_0000;
      send(mk(6'd0, 5'd3, 5'd4, 5'd2, 5'd0, 6'd36));
      bus.wb_en = 1'b0;
      total++;
      if ({bus.out_a, bus.out_b, bus.out_sel} !== {32'd5, 32'hFFFF_0000, 3'b010}) begin
         bad++; $display("FAIL bypass_and: got a=%h b=%h sel=%b want 5 ffff0000 010",
                         bus.out_a, bus.out_b, bus.out_sel);
      end
      do_wb(5'd0, 32'h0000_1234);
      send(mk(6'd0, 5'd0, 5'd4, 5'd7, 5'd0, 6'd32));
      total++;
      if ({bus.out_a, bus.out_b} !== {32'd0, 32'hFFFF_0000}) begin
         bad++; $display("FAIL r0_read: got a=%h b=%h want 0 ffff0000", bus.out_a, bus.out_b);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] want_b;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      send(mk(6'd0, 5'd3, 5'd4, 5'd8, 5'd0, 6'd37));
      bus.in_valid = 1'b1;
      bus.in_instr = mk(6'd0, 5'd4, 5'd3, 5'd9, 5'd0, 6'd38);
      for (int k = 0; k < 3; k++) begin
         if (k == 1) begin bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h0000_A5A5; end
         step();
         bus.wb_en = 1'b0;
         want_b = (k >= 1) ? 32'h0000_A5A5 : 32'hFFFF_0000;
         total++;
         if ({bus.in_ready, bus.out_valid, bus.out_sel, bus.out_rd, bus.out_illegal, bus.out_a, bus.out_b} !==
             {1'b0, 1'b1, 3'b011, 5'd8, 1'b0, 32'd5, want_b}) begin
            bad++; $display("FAIL held_%0d: got rdy=%b v=%b sel=%b rd=%0d a=%h b=%h want 0 1 011 8 5 %h",
                            k, bus.in_ready, bus.out_valid, bus.out_sel, bus.out_rd, bus.out_a, bus.out_b, want_b);
         end
      end
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      total++;
      if ({bus.out_valid, bus.out_rd, bus.out_sel, bus.out_a, bus.out_b} !==
          {1'b1, 5'd9, 3'b100, 32'h0000_A5A5, 32'd5}) begin
         bad++; $display("FAIL release_next: got v=%b rd=%0d sel=%b a=%h b=%h want 1 9 100 a5a5 5",
                         bus.out_valid, bus.out_rd, bus.out_sel, bus.out_a, bus.out_b);
      end
      step();
      total++;
      if (bus.out_valid !== 1'b0 || sb.size() != 0) begin
         bad++; $display("FAIL release_drain: got v=%b pending=%0d want 0 0", bus.out_valid, sb.size());
      end
   endtask

   task automatic test_illegal();
      bus.out_ready = 1'b1;
      send(mk(6'd8, 5'd3, 5'd4, 5'd10, 5'd0, 6'd32));
      total++;
      if ({bus.out_illegal, bus.out_sel, bus.out_a, bus.out_b, bus.out_rd} !== {1'b1, 3'b000, 32'd0, 32'd0, 5'd10}) begin
         bad++; $display("FAIL illegal_opcode: got ill=%b sel=%b a=%h b=%h rd=%0d want 1 000 0 0 10",
                         bus.out_illegal, bus.out_sel, bus.out_a, bus.out_b, bus.out_rd);
      end
      send(mk(6'd0, 5'd3, 5'd4, 5'd11, 5'd0, 6'd42));
      total++;
      if ({bus.out_illegal, bus.out_sel, bus.out_a, bus.out_b, bus.out_rd} !== {1'b1, 3'b000, 32'd0, 32'd0, 5'd11}) begin
         bad++; $display("FAIL illegal_funct: got ill=%b sel=%b a=%h b=%h rd=%0d want 1 000 0 0 11",
                         bus.out_illegal, bus.out_sel, bus.out_a, bus.out_b, bus.out_rd);
      end
      bus.out_ready = 1'b0;
      do_wb(5'd4, 32'h0000_7777);
      total++;
      if ({bus.out_valid, bus.out_illegal, bus.out_a, bus.out_b} !== {1'b1, 1'b1, 32'd0, 32'd0}) begin
         bad++; $display("FAIL illegal_no_refresh: got v=%b ill=%b a=%h b=%h want 1 1 0 0",
                         bus.out_valid, bus.out_illegal, bus.out_a, bus.out_b);
      end
      bus.out_ready = 1'b1;
      step();
   endtask

   task automatic test_reset_midflight();
      bus.out_ready = 1'b0;
      send(mk(6'd0, 5'd3, 5'd4, 5'd13, 5'd0, 6'd32));
      rst = 1'b1;
      bus.in_valid = 1'b1; bus.in_instr = mk(6'd0, 5'd5, 5'd5, 5'd14, 5'd0, 6'd32);
      bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
      step();
      rst = 1'b0; bus.in_valid = 1'b0; bus.wb_en = 1'b0;
      total++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         bad++; $display("FAIL midflight_reset: got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
      end
      bus.out_ready = 1'b1;
      for (int i = 1; i < 32; i++) begin
         send(mk(6'd0, i[4:0], i[4:0], i[4:0], 5'd0, 6'd32));
         total++;
         if ({bus.out_a, bus.out_b} !== {RV, RV}) begin
            bad++; $display("FAIL reg_reset_%0d: got a=%h b=%h want %h", i, bus.out_a, bus.out_b, RV);
         end
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [5:0] fl [8];
      logic [5:0] op, fn;
      int r;
      fl = '{6'd32, 6'd24, 6'd36, 6'd37, 6'd38, 6'd39, 6'd0, 6'd2};
      for (int n = 0; n < 400; n++) begin
         r  = $urandom_range(0, 9);
         op = (r == 9) ? 6'($urandom_range(1, 63)) : 6'd0;
         fn = (r < 8) ? fl[r] : 6'($urandom_range(0, 63));
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_instr  = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), fn};
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.wb_en     = ($urandom_range(0, 1) != 0);
         bus.wb_addr   = 5'($urandom_range(0, 7));
         bus.wb_data   = $urandom;
         step();
      end
      bus.in_valid = 1'b0; bus.wb_en = 1'b0; bus.out_ready = 1'b1;
      step();
      step();
      total++;
      if (bus.out_valid !== 1'b0 || sb.size() != 0) begin
         bad++; $display("FAIL stream_drain: got v=%b pending=%0d want 0 0", bus.out_valid, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_shift();
      test_bypass();
      test_backpressure();
      test_illegal();
      test_reset_midflight();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
